// File: rtl/timer_counter.sv
// Memory-mapped down-counting timer with one-shot and auto-reload modes.
// Optional prescaler enabled by defining TIMER_PRESCALE_EN.
module timer_counter #(
    parameter int CNT_W = 32
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:2] Addr,
    input  logic        WE,
    input  logic [31:0] Din,
    output logic [31:0] Dout,
    output logic        IRQ
);

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        LOAD = 2'b01,
        CNT  = 2'b10,
        INT  = 2'b11
    } state_t;

    localparam logic [1:0] MODE_RELOAD = 2'b01;

    state_t             state;
    state_t             state_next;
    logic               en;
    logic [1:0]         mode;
    logic               im;
    logic [CNT_W-1:0]   preset;
    logic [CNT_W-1:0]   count;
    logic               irq_flag;

    logic               wr_ctrl;
    logic               wr_preset;
    logic               en_eff;
    logic               tick;
    logic               do_load;
    logic               do_dec;
    logic               do_term;
    logic               do_en_clr;
    logic               do_irq_clr;

    // Upper address bits and unused data bits are decoded by the Bridge.
    logic               unused_bits;
    assign unused_bits = ^{Addr[31:4], Din};

    assign wr_ctrl   = WE && (Addr[3:2] == 2'b00);
    assign wr_preset = WE && (Addr[3:2] == 2'b01);

    // The FSM reacts to a CTRL write on the same edge it lands, so enabling
    // reaches LOAD one edge after the write and disabling freezes COUNT at once.
    assign en_eff = wr_ctrl ? Din[0] : en;

`ifdef TIMER_PRESCALE_EN
    logic [15:0] prescale;
    logic [15:0] psc_cnt;

    assign tick = (psc_cnt == prescale);

    always_ff @(posedge clk) begin
        if (reset) begin
            prescale <= '0;
            psc_cnt  <= '0;
        end else begin
            if (WE && (Addr[3:2] == 2'b11))
                prescale <= Din[15:0];
            if (do_load)
                psc_cnt <= '0;
            else if (state == CNT && en_eff)
                psc_cnt <= tick ? 16'd0 : psc_cnt + 16'd1;
        end
    end
`else
    assign tick = 1'b1;
`endif

    // NOTE: every output of this block gets a default before the case, so no
    // path leaves a signal unassigned and no latch is inferred.
    always_comb begin
        state_next = state;
        do_load    = 1'b0;
        do_dec     = 1'b0;
        do_term    = 1'b0;
        do_en_clr  = 1'b0;
        do_irq_clr = 1'b0;
        case (state)
            IDLE: begin
                if (en_eff)
                    state_next = LOAD;
            end
            LOAD: begin
                do_load    = 1'b1;
                state_next = CNT;
            end
            CNT: begin
                if (!en_eff) begin
                    state_next = IDLE;
                end else if (tick) begin
                    if (count > CNT_W'(1)) begin
                        do_dec = 1'b1;
                    end else begin
                        do_term    = 1'b1;
                        state_next = INT;
                    end
                end
            end
            INT: begin
                state_next = IDLE;
                if (mode == MODE_RELOAD)
                    do_irq_clr = 1'b1;
                else
                    do_en_clr = 1'b1;
            end
            default: state_next = IDLE;
        endcase
    end

    // NOTE: state is updated with non-blocking assignments so every register
    // in this block samples the pre-edge values, independent of statement order.
    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= IDLE;
            en       <= 1'b0;
            mode     <= 2'b00;
            im       <= 1'b0;
            preset   <= '0;
            count    <= '0;
            irq_flag <= 1'b0;
        end else begin
            state <= state_next;

            // A CPU write to CTRL wins over the one-shot EN clear.
            if (wr_ctrl) begin
                en   <= Din[0];
                mode <= Din[2:1];
                im   <= Din[3];
            end else if (do_en_clr) begin
                en <= 1'b0;
            end

            if (wr_preset)
                preset <= Din[CNT_W-1:0];

            if (do_load)
                count <= preset;
            else if (do_dec)
                count <= count - CNT_W'(1);
            else if (do_term)
                count <= '0;

            // A terminal count is never lost to a coincident register write.
            if (do_term)
                irq_flag <= 1'b1;
            else if (wr_ctrl || wr_preset || do_irq_clr)
                irq_flag <= 1'b0;
        end
    end

    assign IRQ = im & irq_flag;

    always_comb begin
        Dout = 32'd0;
        case (Addr[3:2])
            2'b00:   Dout = {28'd0, im, mode, en};
            2'b01:   Dout = 32'(preset);
            2'b10:   Dout = 32'(count);
`ifdef TIMER_PRESCALE_EN
            2'b11:   Dout = {16'd0, prescale};
`endif
            default: Dout = 32'd0;
        endcase
    end

endmodule

// File: tb/tb_timer_counter.sv
// Directed self-checking bench for timer_counter; expected values are
// hand-derived edge counts from the enabling CTRL write.
module tb_timer_counter;

    logic        clk;
    logic        reset;
    logic [31:2] Addr;
    logic        WE;
    logic [31:0] Din;
    logic [31:0] Dout;
    logic        IRQ;

    int n_checks = 0;
    int n_fail   = 0;

    timer_counter #(.CNT_W(32)) dut (
        .clk  (clk),
        .reset(reset),
        .Addr (Addr),
        .WE   (WE),
        .Din  (Din),
        .Dout (Dout),
        .IRQ  (IRQ)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Leaves the bench 1 ns after the edge that performed the write.
    task automatic wr(input logic [1:0] a, input logic [31:0] d);
        Addr = 30'(a);
        Din  = d;
        WE   = 1'b1;
        @(posedge clk);
        #1;
        WE   = 1'b0;
        Din  = 32'd0;
    endtask

    task automatic rd(input logic [1:0] a, output logic [31:0] d);
        Addr = 30'(a);
        #1;
        d = Dout;
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic chk_reg(input string tag, input logic [1:0] a, input logic [31:0] exp);
        logic [31:0] d;
        rd(a, d);
        check(tag, d, exp);
    endtask

    task automatic chk_irq(input string tag, input logic exp);
        check(tag, {31'd0, IRQ}, {31'd0, exp});
    endtask

    initial begin
        reset = 1'b1;
        WE    = 1'b0;
        Addr  = '0;
        Din   = 32'd0;
        step(2);
        reset = 1'b0;

        // Reset state
        chk_reg("rst_ctrl",   2'd0, 32'd0);
        chk_reg("rst_preset", 2'd1, 32'd0);
        chk_reg("rst_count",  2'd2, 32'd0);
        chk_reg("rst_addr3",  2'd3, 32'd0);
        chk_irq("rst_irq", 1'b0);

        // Mode 0, PRESET=5: COUNT 5..1 after edges 2..6, IRQ after edge 7
        wr(2'd1, 32'd5);
        wr(2'd0, 32'h9);
        step(1);
        chk_reg("m0_count_e2", 2'd2, 32'd5);
        chk_irq("m0_irq_e2", 1'b0);
        for (int k = 4; k >= 1; k--) begin
            step(1);
            chk_reg($sformatf("m0_count_%0d", k), 2'd2, 32'(k));
        end
        chk_irq("m0_irq_e6", 1'b0);
        step(1);
        chk_irq("m0_irq_e7", 1'b1);
        chk_reg("m0_count_e7", 2'd2, 32'd0);
        step(1);
        chk_reg("m0_ctrl_after", 2'd0, 32'h8);
        step(3);
        chk_irq("m0_irq_held", 1'b1);
        wr(2'd0, 32'h8);
        chk_irq("m0_irq_cleared", 1'b0);

        // Mode 1, PRESET=5: one-cycle pulses after edges 7, 15, 23
        wr(2'd1, 32'd5);
        wr(2'd0, 32'hB);
        step(5);
        chk_irq("m1_irq_e6", 1'b0);
        step(1);
        chk_irq("m1_irq_e7", 1'b1);
        step(1);
        chk_irq("m1_irq_e8", 1'b0);
        step(6);
        chk_irq("m1_irq_e14", 1'b0);
        step(1);
        chk_irq("m1_irq_e15", 1'b1);
        step(1);
        chk_irq("m1_irq_e16", 1'b0);
        step(7);
        chk_irq("m1_irq_e23", 1'b1);
        step(1);
        chk_irq("m1_irq_e24", 1'b0);
        chk_reg("m1_ctrl_en", 2'd0, 32'hB);
        wr(2'd0, 32'h0);

        // Masked interrupt, PRESET=3
        wr(2'd1, 32'd3);
        wr(2'd0, 32'h1);
        step(4);
        chk_irq("mask_irq_e5", 1'b0);
        chk_reg("mask_count_e5", 2'd2, 32'd0);
        step(1);
        chk_reg("mask_ctrl_idle", 2'd0, 32'h0);
        chk_reg("mask_count_idle", 2'd2, 32'd0);
        wr(2'd0, 32'h8);
        chk_irq("mask_irq_after_im", 1'b0);

        // Disable mid-count at COUNT=6, then re-enable reloads 10
        wr(2'd1, 32'd10);
        wr(2'd0, 32'h1);
        step(5);
        chk_reg("dis_count_e6", 2'd2, 32'd6);
        wr(2'd0, 32'h0);
        chk_reg("dis_count_hold", 2'd2, 32'd6);
        step(3);
        chk_reg("dis_count_later", 2'd2, 32'd6);
        chk_irq("dis_irq", 1'b0);
        wr(2'd2, 32'h55);
        chk_reg("count_write_ignored", 2'd2, 32'd6);
        wr(2'd0, 32'h1);
        step(1);
        chk_reg("reen_count", 2'd2, 32'd10);

        // PRESET=0 behaves as 1: IRQ after edge 3
        wr(2'd0, 32'h0);
        wr(2'd1, 32'd0);
        wr(2'd0, 32'h9);
        step(1);
        chk_irq("p0_irq_e2", 1'b0);
        step(1);
        chk_irq("p0_irq_e3", 1'b1);

        // Reset mid-count
        wr(2'd0, 32'h0);
        wr(2'd1, 32'd10);
        wr(2'd0, 32'h9);
        step(3);
        reset = 1'b1;
        step(1);
        reset = 1'b0;
        chk_reg("mrst_ctrl",   2'd0, 32'd0);
        chk_reg("mrst_preset", 2'd1, 32'd0);
        chk_reg("mrst_count",  2'd2, 32'd0);
        step(3);
        chk_reg("mrst_count_idle", 2'd2, 32'd0);
        chk_irq("mrst_irq", 1'b0);

`ifdef TIMER_PRESCALE_EN
        // PRESCALE=2, PRESET=4: IRQ after edge 4*3+2 = 14
        wr(2'd3, 32'd2);
        chk_reg("psc_readback", 2'd3, 32'd2);
        wr(2'd1, 32'd4);
        wr(2'd0, 32'h9);
        step(12);
        chk_irq("psc_irq_e13", 1'b0);
        step(1);
        chk_irq("psc_irq_e14", 1'b1);
`else
        wr(2'd3, 32'd2);
        chk_reg("addr3_reads_zero", 2'd3, 32'd0);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
